// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op encodings and FSM states for alu_seq_param
// ALU_SEQ_MUL_EN adds the BUSY state used by the sequential multiply.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd1, ST_BUSY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd1} state_t;
`endif

endpackage

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - combinational datapath and flags for single-cycle ops
// MUL and the illegal op both produce a zero result here.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  always_comb begin
    b_eff  = (op == OP_SUB) ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    result = '0;
    cout   = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_NOT:         result = ~a;
      OP_MUL, OP_ILL: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - registered ALU with valid/ready handshakes and FSM
// Define ALU_SEQ_MUL_EN for the WIDTH-cycle shift-add unsigned multiply on op 110.
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] core_result;
  logic             core_cout, core_zero, core_ovf;
  logic             accept;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0]   res_hi_q, res_hi_d, mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_next;
`endif

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .result (core_result),
    .cout   (core_cout),
    .zero   (core_zero),
    .ovf    (core_ovf)
  );

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

`ifdef ALU_SEQ_MUL_EN
  // {res_hi_q, res_q} is the product accumulator; the multiplier shifts out of res_q.
  assign psum      = {1'b0, res_hi_q} + (res_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_next = {psum, res_q[WIDTH-1:1]};
  assign result_hi = res_hi_q;
`else
  assign result_hi = '0;
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`ifdef ALU_SEQ_MUL_EN
    res_hi_d = res_hi_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
`endif
    if (state_q == ST_DONE && out_ready) state_d = ST_IDLE;
`ifdef ALU_SEQ_MUL_EN
    if (state_q == ST_BUSY) begin
      res_d    = prod_next[WIDTH-1:0];
      res_hi_d = prod_next[2*WIDTH-1:WIDTH];
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = ST_DONE;
        zero_d  = (prod_next == '0);
        cnt_d   = '0;
      end
    end
`endif
    if (accept) begin
      state_d = ST_DONE;
      res_d   = core_result;
      cout_d  = core_cout;
      zero_d  = core_zero;
      ovf_d   = core_ovf;
`ifdef ALU_SEQ_MUL_EN
      res_hi_d = '0;
      if (op == OP_MUL) begin
        state_d = ST_BUSY;
        mcand_d = a;
        res_d   = b;
        cnt_d   = '0;
        cout_d  = 1'b0;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      res_hi_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`ifdef ALU_SEQ_MUL_EN
      res_hi_q <= res_hi_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule
